apb_register_slave: RTL
=======================

# apb_register_slave

APB completer holding a bank of 32-bit software registers, the responder at the far end of the APB side of the AXI4-Lite-to-APB bridge. One instance sits behind each slave-select line driven by the bridge's address decoder. It decodes its own address window, inserts a configurable number of wait states, and completes reads and writes. Out-of-window or misaligned accesses are flagged with `pslverr`. Register contents are exported on a flat bus for the surrounding logic.

## Interface
- `c_num_regs`, 8: number of 32-bit registers, 1..256.
- `c_base_addr`, 32'h0000_0000: byte address of register 0, 4-byte aligned.
- `c_wait_states`, 0: access-phase cycles with `pready` low before completion, 0..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `psel` input 1: slave select from the bridge.
- `penable` input 1: access-phase indicator.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input 32: byte address.
- `pwdata` input 32: write data.
- `pstrb` input 4: byte-lane write strobes. Present only with `APB_REG_SLAVE_PSTRB_EN`.
- `prdata` output 32: read data.
- `pready` output 1: transfer-complete, registered.
- `pslverr` output 1: error response, registered.
- `reg_out` output 32*`c_num_regs`: register contents; register i at bits [32i+31:32i].

## Operation
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, all registers 0, FSM in IDLE.
- FSM has two states, IDLE and ACCESS.
- IDLE → ACCESS on the setup phase (`psel`=1, `penable`=0). At that edge the block:
  - loads wait counter `cnt`=`c_wait_states`;
  - latches address, direction, data and strobes;
  - evaluates the error flag;
  - sets `pready` to (`c_wait_states`==0).
- ACCESS with `pready`=0: `cnt` decrements; `pready` is set when `cnt`==1.
- ACCESS with `pready`=1 and `psel`&`penable`: the transfer completes at this edge.
  - Write without error: commits to the register.
  - Always: `pready`, `pslverr` and `prdata` are cleared; FSM returns to IDLE.
- ACCESS with `psel`=0 (protocol abort): the block returns to IDLE and clears its outputs. No write is committed.
- Address decode on the captured address:
  - `off` = `paddr` − `c_base_addr` (32-bit);
  - error if `paddr` < `c_base_addr`, or `off[1:0]`≠0, or `off[31:2]` ≥ `c_num_regs`.
- Error write: no register changes. Error read: `prdata`=0.
- `pslverr` and `prdata` may be nonzero only while `pready`=1. Read data is sampled when `pready` is set.
- Back-to-back transfers: a setup phase in the cycle after completion is accepted from IDLE with no idle cycle.
- Reset mid-transfer: outputs and registers are cleared immediately; the in-flight write is lost.

## Timing
- Setup at cycle T; access phase starts at T+1.
- `pready`=1 during cycle T+1+`c_wait_states`.
- Completion at the end of cycle T+1+`c_wait_states`. Minimum transfer is 2 cycles, maximum 17.
- A write is visible on `reg_out` in cycle T+2+`c_wait_states`.
- A read returns the register value as of the edge that sets `pready`. A write committed at that same edge is not visible to that read.

## Configuration
- `APB_REG_SLAVE_PSTRB_EN` defined:
  - `pstrb` port exists;
  - byte lane k is written only when `pstrb[k]`=1;
  - `pstrb`=0 on a write completes normally with no change.
- Not defined: `pstrb` is absent and every write updates all 32 bits.

## Structure
- Package `apb_slave_pkg` holds:
  - FSM state type (IDLE, ACCESS);
  - data width 32 and strobe width 4;
  - wait-counter width 4.
- Sub-module `apb_reg_bank` holds register storage, byte-lane write enable and the read mux. It is instantiated once. FSM, counter and decode stay in the top module.

## Test plan
- Reset, then read offset 0x4 with `c_wait_states`=0 → `pready`=1 in the first access cycle, `prdata`=0, `pslverr`=0.
- Write 0xDEAD_BEEF to base+0x8, read it back with `c_wait_states`=3 → `pready` low for 3 access cycles, `prdata`=0xDEAD_BEEF, and `reg_out[95:64]`=0xDEAD_BEEF.
- Access base+0x20 with `c_num_regs`=8, then base+0x6 → both give `pslverr`=1 with `pready`. The reads return 0, the writes change nothing.
- With `PSTRB_EN`: register holds 0x1122_3344; write 0xAABB_CCDD with `pstrb`=4'b0101 → value becomes 0x11BB_33DD.
- Back-to-back write then read of the same register, with no idle cycle → second setup accepted; read returns the new value.
- Assert `rst` during a write access at wait count 2 → `pready`=0 and the register stays 0. A subsequent read completes normally.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared widths and FSM state encoding for the APB register completer.
package apb_slave_pkg;

    localparam int c_data_w = 32;
    localparam int c_strb_w = 4;
    localparam int c_cnt_w  = 4;

    typedef logic [0:0] state_t;
    localparam state_t st_idle   = 1'b0;
    localparam state_t st_access = 1'b1;

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage, byte-lane write enable and read mux for apb_register_slave.
module apb_reg_bank
    import apb_slave_pkg::*;
#(
    parameter int c_num_regs = 8,
    parameter int c_idx_w    = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [c_idx_w-1:0]             widx,
    input  logic [c_data_w-1:0]            wdata,
    input  logic [c_strb_w-1:0]            wstrb,
    input  logic [c_idx_w-1:0]             ridx,
    output logic [c_data_w-1:0]            rdata,
    output logic [c_data_w*c_num_regs-1:0] reg_out
);

    logic [c_data_w-1:0] regs [c_num_regs];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_num_regs; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < c_strb_w; k++) begin
                if (wstrb[k]) begin
                    regs[widx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Guard keeps non-power-of-two banks from reading past the last entry.
    always_comb begin
        rdata = '0;
        if ({{(32-c_idx_w){1'b0}}, ridx} < 32'(c_num_regs)) begin
            rdata = regs[ridx];
        end
    end

    for (genvar g = 0; g < c_num_regs; g++) begin : g_out
        assign reg_out[c_data_w*g +: c_data_w] = regs[g];
    end

endmodule

// File: rtl/apb_register_slave.sv
// APB completer with a bank of 32-bit registers, programmable wait states and error decode.
// Optional byte-lane strobes enabled by defining APB_REG_SLAVE_PSTRB_EN.
//
// state     | meaning
// st_idle   | waiting for a setup phase (psel=1, penable=0)
// st_access | access phase; counting wait states, then completing on psel&penable
module apb_register_slave
    import apb_slave_pkg::*;
#(
    parameter int          c_num_regs    = 8,
    parameter logic [31:0] c_base_addr   = 32'h0000_0000,
    parameter int          c_wait_states = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [31:0]                    paddr,
    input  logic [c_data_w-1:0]            pwdata,
`ifdef APB_REG_SLAVE_PSTRB_EN
    input  logic [c_strb_w-1:0]            pstrb,
`endif
    output logic [c_data_w-1:0]            prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [c_data_w*c_num_regs-1:0] reg_out
);

    localparam int c_idx_w = (c_num_regs > 1) ? $clog2(c_num_regs) : 1;

    state_t               state;
    logic [c_cnt_w-1:0]   cnt;
    logic [31:0]          addr_q;
    logic                 write_q;
    logic                 err_q;
    logic [c_data_w-1:0]  wdata_q;
    logic [c_strb_w-1:0]  strb_q;
    logic [c_strb_w-1:0]  strb_in;
    logic [31:0]          off_in;
    logic [31:0]          off_q;
    logic                 err_in;
    logic [c_idx_w-1:0]   idx_in;
    logic [c_idx_w-1:0]   idx_q;
    logic [c_idx_w-1:0]   rd_idx;
    logic [c_data_w-1:0]  rdata;
    logic                 bank_we;

`ifdef APB_REG_SLAVE_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    assign off_in = paddr - c_base_addr;
    assign off_q  = addr_q - c_base_addr;
    assign err_in = (paddr < c_base_addr) || (off_in[1:0] != 2'b00) ||
                    ({2'b00, off_in[31:2]} >= 32'(c_num_regs));
    assign idx_in = off_in[c_idx_w+1:2];
    assign idx_q  = off_q[c_idx_w+1:2];

    // With zero wait states the read is sampled at the setup edge, before addr_q is valid.
    assign rd_idx  = (state == st_idle) ? idx_in : idx_q;
    assign bank_we = (state == st_access) && pready && psel && penable && write_q && !err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= st_idle;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (psel && !penable) begin
                        state   <= st_access;
                        cnt     <= c_cnt_w'(c_wait_states);
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        err_q   <= err_in;
                        wdata_q <= pwdata;
                        strb_q  <= strb_in;
                        if (c_wait_states == 0) begin
                            pready  <= 1'b1;
                            pslverr <= err_in;
                            prdata  <= (!pwrite && !err_in) ? rdata : '0;
                        end
                    end
                end
                st_access: begin
                    if (!psel) begin
                        state   <= st_idle;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end else if (!pready) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == c_cnt_w'(1)) begin
                            pready  <= 1'b1;
                            pslverr <= err_q;
                            prdata  <= (!write_q && !err_q) ? rdata : '0;
                        end
                    end else if (penable) begin
                        state   <= st_idle;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    apb_reg_bank #(
        .c_num_regs (c_num_regs),
        .c_idx_w    (c_idx_w)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we),
        .widx    (idx_q),
        .wdata   (wdata_q),
        .wstrb   (strb_q),
        .ridx    (rd_idx),
        .rdata   (rdata),
        .reg_out (reg_out)
    );

endmodule
